// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the asynchronous FIFO read and write controllers.
// Latency: combinational functions only.
// Backpressure: n/a (no handshake in a package).
package fifo_pkg;

    // Default memory address width; depth is 2**FIFO_ADDR_WIDTH and pointers
    // carry one extra wrap bit.
    localparam int FIFO_ADDR_WIDTH = 4;

    // Helpers operate on a 32-bit container so that any pointer width up to
    // 31 bits can use them. Gray<->binary conversion only propagates
    // from MSB to LSB, so zero-extending a narrower pointer and taking the
    // low bits of the result gives the exact answer for that width.
    localparam int FIFO_FN_WIDTH = 32;

    function automatic logic [FIFO_FN_WIDTH-1:0] bin2gray(input logic [FIFO_FN_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FIFO_FN_WIDTH-1:0] gray2bin(input logic [FIFO_FN_WIDTH-1:0] g);
        logic [FIFO_FN_WIDTH-1:0] b;
        b[FIFO_FN_WIDTH-1] = g[FIFO_FN_WIDTH-1];
        for (int i = FIFO_FN_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded bus crossing into the clk domain.
// Latency: 2 clk edges from d to q.
// Backpressure: none; d must change by at most one bit per source clock.
//
// Ports: clk, rst_n (async active-low, clears both stages to 0),
//        d (asynchronous input bus), q (synchronized output bus).
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q1;

    // No logic between d and the first stage: the first flop may go
    // metastable and must only feed the second flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            q       <= '0;
        end else begin
            sync_q1 <= d;
            q       <= sync_q1;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/flag controller of the async FIFO (rclk domain only).
// Latency: pop updates raddr/rptr/flags at the same edge; wptr change seen 3 edges later.
// Backpressure: pops while rempty=1 are ignored and latch the sticky runderflow flag.
//
// Ports: rclk, rrst_n (async active-low), rinc (pop request),
//        wptr (Gray write pointer, async), raddr (memory read address),
//        rptr (Gray read pointer to write side), rempty, raempty,
//        rlevel (conservative occupancy 0..depth), runderflow (sticky).
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rinc,
    input  logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic                  rempty,
    output logic                  raempty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic                  runderflow
);

    localparam int              PW       = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]   AE_LIMIT = PW'(AEMPTY_THRESH);

    logic [PW-1:0]              rq2_wptr;
    logic [PW-1:0]              rbin;
    logic [PW-1:0]              rbinnext;
    logic [PW-1:0]              rgraynext;
    logic [PW-1:0]              wbin_s;
    logic [PW-1:0]              levelnext;
    logic [FIFO_FN_WIDTH-1:0]   wbin_full;
    logic                       unused_wbin_hi;
    logic                       rpop;

    sync_2ff #(
        .WIDTH (PW)
    ) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (wptr),
        .q     (rq2_wptr)
    );

    assign rpop      = rinc & ~rempty;
    assign rbinnext  = rbin + {{ADDR_WIDTH{1'b0}}, rpop};
    assign rgraynext = rbinnext ^ (rbinnext >> 1);

    // Write count as last seen in this domain; it lags the real write
    // pointer, so the level derived from it can only under-report.
    assign wbin_full      = gray2bin(FIFO_FN_WIDTH'(rq2_wptr));
    assign wbin_s         = wbin_full[PW-1:0];
    assign unused_wbin_hi = ^wbin_full[FIFO_FN_WIDTH-1:PW];

    // Modulo 2**PW difference; the extra pointer bit lets a full FIFO
    // report exactly 2**ADDR_WIDTH rather than aliasing to 0.
    assign levelnext = wbin_s - rbinnext;

    assign raddr = rbin[ADDR_WIDTH-1:0];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin       <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            raempty    <= 1'b1;
            rlevel     <= '0;
            runderflow <= 1'b0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            // Gray equality is the same test as levelnext == 0, but does not
            // wait on the gray-to-binary chain.
            rempty  <= (rgraynext == rq2_wptr);
            raempty <= (levelnext <= AE_LIMIT);
            rlevel  <= levelnext;
            if (rinc && rempty) begin
                runderflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: count-based occupancy model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_rd_ctrl;

    logic       rclk;
    logic       rrst_n;
    logic       rinc;
    logic [4:0] wptr;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [4:0] rlevel;
    logic       runderflow;

    int checks = 0;
    int errors = 0;

    // Model state: plain counts of entries written/read, no wrap handling.
    int w_cnt   = 0;   // writes represented by the wptr currently driven
    int m_r     = 0;   // entries popped
    int m_s1    = 0;   // write count sampled one edge ago
    int m_s2    = 0;   // write count sampled two edges ago
    int m_level = 0;
    bit m_empty  = 1'b1;
    bit m_aempty = 1'b1;
    bit m_uf     = 1'b0;

    fifo_rd_ctrl #(
        .ADDR_WIDTH    (4),
        .AEMPTY_THRESH (2)
    ) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rinc       (rinc),
        .wptr       (wptr),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rlevel     (rlevel),
        .runderflow (runderflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic int gray5(input int n);
        int b;
        b = n % 32;
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_w(input int n);
        w_cnt = n;
        wptr  = 5'(gray5(n));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge rclk);
    endtask

    // Reset asserted mid-cycle, released on a falling edge.
    task automatic do_reset(input logic pop_at_release);
        @(posedge rclk);
        #2;
        rrst_n = 1'b0;
        rinc   = pop_at_release;
        set_w(0);
        tick(2);
        rrst_n = 1'b1;
    endtask

    // Occupancy model: the level seen after an edge is the write count from
    // two edges earlier minus everything popped so far.
    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            m_r      = 0;
            m_s1     = 0;
            m_s2     = 0;
            m_level  = 0;
            m_empty  = 1'b1;
            m_aempty = 1'b1;
            m_uf     = 1'b0;
        end else begin
            if (rinc && m_empty) m_uf = 1'b1;
            if (rinc && !m_empty) m_r = m_r + 1;
            m_level  = m_s2 - m_r;
            m_empty  = (m_level == 0);
            m_aempty = (m_level <= 2);
            m_s2     = m_s1;
            m_s1     = w_cnt;
        end
    end

    always @(negedge rclk) begin
        chk("cyc_raddr",      int'(raddr),      m_r % 16);
        chk("cyc_rptr",       int'(rptr),       gray5(m_r));
        chk("cyc_rlevel",     int'(rlevel),     m_level);
        chk("cyc_rempty",     int'(rempty),     int'(m_empty));
        chk("cyc_raempty",    int'(raempty),    int'(m_aempty));
        chk("cyc_runderflow", int'(runderflow), int'(m_uf));
    end

    initial begin
        int exp_rptr [6];
        exp_rptr = '{1, 3, 2, 6, 7, 7};

        rrst_n = 1'b0;
        rinc   = 1'b0;
        set_w(0);
        tick(2);
        chk("rst_rempty",     int'(rempty),     1);
        chk("rst_raempty",    int'(raempty),    1);
        chk("rst_raddr",      int'(raddr),      0);
        chk("rst_rptr",       int'(rptr),       0);
        chk("rst_rlevel",     int'(rlevel),     0);
        chk("rst_runderflow", int'(runderflow), 0);
        rrst_n = 1'b1;

        // Single write visibility
        tick(1);
        set_w(1);
        tick(2);
        chk("w1_still_empty", int'(rempty), 1);
        tick(1);
        chk("w1_rempty",  int'(rempty),  0);
        chk("w1_rlevel",  int'(rlevel),  1);
        chk("w1_raempty", int'(raempty), 1);

        // Drain 5 entries plus one underflowing pop
        set_w(5);
        tick(3);
        chk("d5_rlevel", int'(rlevel), 5);
        rinc = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            chk("d5_raddr_pre", int'(raddr), (k <= 5) ? k - 1 : 5);
            tick(1);
            chk("d5_rptr",       int'(rptr),       exp_rptr[k-1]);
            chk("d5_rlevel",     int'(rlevel),     (k <= 5) ? 5 - k : 0);
            chk("d5_rempty",     int'(rempty),     (k >= 5) ? 1 : 0);
            chk("d5_raempty",    int'(raempty),    (k >= 3) ? 1 : 0);
            chk("d5_runderflow", int'(runderflow), (k == 6) ? 1 : 0);
        end
        rinc = 1'b0;
        chk("d5_raddr_hold", int'(raddr), 5);

        // Mid-cycle reset pulse clears outputs before the next edge
        @(posedge rclk);
        #2;
        rrst_n = 1'b0;
        set_w(0);
        #1;
        chk("mid_rempty",     int'(rempty),     1);
        chk("mid_raempty",    int'(raempty),    1);
        chk("mid_raddr",      int'(raddr),      0);
        chk("mid_rptr",       int'(rptr),       0);
        chk("mid_rlevel",     int'(rlevel),     0);
        chk("mid_runderflow", int'(runderflow), 0);
        rrst_n = 1'b1;
        tick(1);

        // Underflow is sticky
        do_reset(1'b1);
        tick(1);
        chk("uf_set", int'(runderflow), 1);
        rinc = 1'b0;
        set_w(1);
        tick(1);
        set_w(2);
        tick(4);
        chk("uf_after_write", int'(runderflow), 1);
        rinc = 1'b1;
        tick(2);
        rinc = 1'b0;
        chk("uf_after_pop", int'(runderflow), 1);
        chk("uf_level0",    int'(rlevel),     0);
        tick(1);

        // Full level and wrap
        do_reset(1'b0);
        tick(1);
        set_w(16);
        tick(3);
        chk("full_rlevel",  int'(rlevel),  16);
        chk("full_raempty", int'(raempty), 0);
        chk("full_rempty",  int'(rempty),  0);
        rinc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("wrap_raddr", int'(raddr), i);
            tick(1);
        end
        rinc = 1'b0;
        chk("wrap_rptr",   int'(rptr),   8'h18);
        chk("wrap_rempty", int'(rempty), 1);
        chk("wrap_raddr0", int'(raddr),  0);
        set_w(17);
        tick(3);
        chk("wrap_w17_rlevel", int'(rlevel), 1);
        chk("wrap_w17_raddr",  int'(raddr),  0);

        // Pop in the same cycle as a write
        set_w(18);
        tick(1);
        set_w(19);
        tick(3);
        chk("sim_level3", int'(rlevel), 3);
        rinc = 1'b1;
        set_w(20);
        tick(1);
        rinc = 1'b0;
        chk("sim_level2",  int'(rlevel), 2);
        chk("sim_nempty1", int'(rempty), 0);
        tick(1);
        chk("sim_level2b", int'(rlevel), 2);
        chk("sim_nempty2", int'(rempty), 0);
        tick(1);
        chk("sim_level3b", int'(rlevel), 3);
        chk("sim_nempty3", int'(rempty), 0);

        // Randomized traffic: write-heavy, then read-heavy, then balanced
        do_reset(1'b0);
        for (int c = 0; c < 3000; c++) begin
            int wp;
            int rp;
            wp = (c < 1000) ? 80 : (c < 2000) ? 30 : 55;
            rp = (c < 1000) ? 25 : (c < 2000) ? 80 : 55;
            rinc = ($urandom_range(0, 99) < rp);
            if ((w_cnt - m_r) < 16 && $urandom_range(0, 99) < wp) begin
                set_w(w_cnt + 1);
            end
            tick(1);
        end
        rinc = 1'b0;
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
